// File: rtl/io_register_bank_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Interface : io_register_bank_if                                      |
// | Purpose   : CPU-side access port of io_register_bank. The master     |
// |             drives access requests and the slave returns the         |
// |             registered response and the register state.              |
// | Revision  : 1.0 - initial release                                    |
// +----------------------------------------------------------------------+
interface io_register_bank_if #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 8,
  parameter int ADDR_WIDTH = 3
) ();
  logic                           enable;
  logic                           write;
  logic [ADDR_WIDTH-1:0]          addr;
  logic [DATA_WIDTH/8-1:0]        byte_en;
  logic [DATA_WIDTH-1:0]          data_in;
  logic [DATA_WIDTH-1:0]          r_data_out;
  logic                           r_valid;
  logic                           r_err;
  logic [NUM_REGS-1:0]            r_changed;
  logic [NUM_REGS*DATA_WIDTH-1:0] r_mem;

  modport master (
    output enable, write, addr, byte_en, data_in,
    input  r_data_out, r_valid, r_err, r_changed, r_mem
  );

  modport slave (
    input  enable, write, addr, byte_en, data_in,
    output r_data_out, r_valid, r_err, r_changed, r_mem
  );
endinterface
`default_nettype wire

// File: rtl/io_register_bank.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module    : io_register_bank                                         |
// | Purpose   : NUM_REGS control/status registers behind one CPU port,   |
// |             with byte strobes, 1-cycle registered reads, per-reg     |
// |             write-change pulses and an out-of-range error flag.      |
// | Options   : IO_REGISTER_BANK_HW_SET_EN adds hw_we/hw_data ports for  |
// |             full-width loads from peripheral logic.                  |
// | Revision  : 1.0 - initial release                                    |
// +----------------------------------------------------------------------+
module io_register_bank #(
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    NUM_REGS    = 8,
  parameter int                    ADDR_WIDTH  = 3,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
  input  wire logic                           clk_in,
  input  wire logic                           rst_in,
  io_register_bank_if.slave                   bus
`ifdef IO_REGISTER_BANK_HW_SET_EN
  ,
  input  wire logic [NUM_REGS-1:0]            hw_we,
  input  wire logic [NUM_REGS*DATA_WIDTH-1:0] hw_data
`endif
);

  localparam int c_NUM_BYTES = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] mem_q [NUM_REGS];
  logic [DATA_WIDTH-1:0] mem_d [NUM_REGS];
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  valid_q, valid_d;
  logic                  err_q, err_d;
  logic [NUM_REGS-1:0]   changed_q, changed_d;

  logic                  w_in_range;
  logic                  w_sw_write;
  logic                  w_sw_read;
  logic [NUM_REGS-1:0]   w_sel;

  // Decode the access: range check and one-hot register select.
  always_comb begin
    w_in_range = (32'(bus.addr) < NUM_REGS);
    w_sw_write = bus.enable &  bus.write & w_in_range;
    w_sw_read  = bus.enable & ~bus.write & w_in_range;
    for (int i = 0; i < NUM_REGS; i++) begin
      w_sel[i] = (32'(bus.addr) == i);
    end
  end

  // Register next state: hw load first, then a software write to the same
  // register replaces it entirely, merging bytes over the old contents.
  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      mem_d[i] = mem_q[i];
`ifdef IO_REGISTER_BANK_HW_SET_EN
      if (hw_we[i]) begin
        mem_d[i] = hw_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
`endif
      if (w_sw_write && w_sel[i]) begin
        mem_d[i] = mem_q[i];
        for (int b = 0; b < c_NUM_BYTES; b++) begin
          if (bus.byte_en[b]) begin
            mem_d[i][b*8 +: 8] = bus.data_in[b*8 +: 8];
          end
        end
      end
    end
  end

  // Response stage: reads return pre-edge contents; out-of-range reads
  // still complete with zero data and the error flag.
  always_comb begin
    rdata_d = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (w_sw_read && w_sel[i]) begin
        rdata_d = mem_q[i];
      end
    end
    valid_d   = bus.enable & ~bus.write;
    err_d     = bus.enable & ~w_in_range;
    changed_d = w_sw_write ? w_sel : '0;
  end

  // State update; reset drops any in-flight response and overrides hw loads.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        mem_q[i] <= RESET_VALUE;
      end
      rdata_q   <= '0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
      changed_q <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        mem_q[i] <= mem_d[i];
      end
      rdata_q   <= rdata_d;
      valid_q   <= valid_d;
      err_q     <= err_d;
      changed_q <= changed_d;
    end
  end

  assign bus.r_data_out = rdata_q;
  assign bus.r_valid    = valid_q;
  assign bus.r_err      = err_q;
  assign bus.r_changed  = changed_q;

  // Expose the live register state, reg i at slice i.
  generate
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_mem_flat
      assign bus.r_mem[gi*DATA_WIDTH +: DATA_WIDTH] = mem_q[gi];
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_io_register_bank.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module    : tb_io_register_bank                                      |
// | Purpose   : Directed self-checking bench for io_register_bank with   |
// |             NUM_REGS=6 so that out-of-range addresses are reachable. |
// | Revision  : 1.0 - initial release                                    |
// +----------------------------------------------------------------------+
module tb_io_register_bank;

  localparam int c_DW = 32;
  localparam int c_NR = 6;
  localparam int c_AW = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;
  bit   model_on = 1'b0;

  always #5 clk = ~clk;

  io_register_bank_if #(.DATA_WIDTH(c_DW), .NUM_REGS(c_NR), .ADDR_WIDTH(c_AW)) bus ();

`ifdef IO_REGISTER_BANK_HW_SET_EN
  logic [c_NR-1:0]      hw_we = '0;
  logic [c_NR*c_DW-1:0] hw_data = '0;
  logic [c_NR-1:0]      hw_we_nx = '0;
  logic [c_NR*c_DW-1:0] hw_data_nx = '0;
`endif

  io_register_bank #(
    .DATA_WIDTH (c_DW),
    .NUM_REGS   (c_NR),
    .ADDR_WIDTH (c_AW),
    .RESET_VALUE(32'h0)
  ) u_dut (
    .clk_in (clk),
    .rst_in (rst),
    .bus    (bus)
`ifdef IO_REGISTER_BANK_HW_SET_EN
    ,
    .hw_we  (hw_we),
    .hw_data(hw_data)
`endif
  );

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Behavioural model: register array plus expected response per cycle.
  logic [c_DW-1:0]      m_mem [c_NR];
  logic [c_DW-1:0]      e_rdata;
  logic                 e_valid, e_err;
  logic [c_NR-1:0]      e_changed;
  logic [c_NR*c_DW-1:0] e_mem;

  initial begin
    logic            en, wr, in_rng;
    logic [c_AW-1:0] a;
    logic [3:0]      be;
    logic [c_DW-1:0] d, old;
    forever begin
      @(posedge clk);
      en = bus.enable; wr = bus.write; a = bus.addr; be = bus.byte_en; d = bus.data_in;
      if (rst === 1'b1) begin
        for (int i = 0; i < c_NR; i++) m_mem[i] = '0;
        e_rdata = '0; e_valid = 0; e_err = 0; e_changed = '0;
        model_on = 1'b1;
      end else if (model_on) begin
        in_rng    = (int'(a) < c_NR);
        e_valid   = en && !wr;
        e_err     = en && !in_rng;
        e_rdata   = (en && !wr && in_rng) ? m_mem[a] : '0;
        e_changed = (en && wr && in_rng) ? c_NR'(1 << a) : '0;
        old       = in_rng ? m_mem[a] : '0;
`ifdef IO_REGISTER_BANK_HW_SET_EN
        for (int i = 0; i < c_NR; i++)
          if (hw_we[i]) m_mem[i] = hw_data[i*c_DW +: c_DW];
`endif
        if (en && wr && in_rng) begin
          m_mem[a] = old;
          for (int b = 0; b < 4; b++)
            if (be[b]) m_mem[a][b*8 +: 8] = d[b*8 +: 8];
        end
      end
      for (int i = 0; i < c_NR; i++) e_mem[i*c_DW +: c_DW] = m_mem[i];
      #1;
      if (model_on) begin
        chk("model_rdata",   256'(bus.r_data_out), 256'(e_rdata));
        chk("model_valid",   256'(bus.r_valid),    256'(e_valid));
        chk("model_err",     256'(bus.r_err),      256'(e_err));
        chk("model_changed", 256'(bus.r_changed),  256'(e_changed));
        chk("model_mem",     256'(bus.r_mem),      256'(e_mem));
      end
    end
  end

  // One access: drive at the falling edge, return just after the sampling edge.
  task automatic cycle(input logic r, input logic en, input logic wr,
                       input logic [c_AW-1:0] a, input logic [3:0] be,
                       input logic [c_DW-1:0] d);
    @(negedge clk);
    rst = r; bus.enable = en; bus.write = wr; bus.addr = a;
    bus.byte_en = be; bus.data_in = d;
`ifdef IO_REGISTER_BANK_HW_SET_EN
    hw_we = hw_we_nx; hw_data = hw_data_nx;
    hw_we_nx = '0; hw_data_nx = '0;
`endif
    @(posedge clk);
    #2;
  endtask

  logic [c_AW-1:0] t_addr [6] = '{3'd0, 3'd1, 3'd3, 3'd4, 3'd5, 3'd0};
  logic [3:0]      t_be   [6] = '{4'hF, 4'h3, 4'hC, 4'h8, 4'h1, 4'h0};
  logic [c_DW-1:0] t_data [6] = '{32'h11111111, 32'hAABBCCDD, 32'h01234567,
                                  32'h89ABCDEF, 32'hCAFEF00D, 32'hFFFFFFFF};

  initial begin
    bus.enable = 0; bus.write = 0; bus.addr = '0; bus.byte_en = '0; bus.data_in = '0;

    cycle(1, 0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0);
    chk("reset_mem",     256'(bus.r_mem),     256'(0));
    chk("reset_valid",   256'(bus.r_valid),   256'(0));
    chk("reset_err",     256'(bus.r_err),     256'(0));
    chk("reset_changed", 256'(bus.r_changed), 256'(0));

    cycle(0, 1, 1, 2, 4'b0101, 32'hDEADBEEF);
    chk("bytestrobe_reg2", 256'(bus.r_mem[2*c_DW +: c_DW]), 256'(32'h00AD00EF));
    chk("bytestrobe_chg",  256'(bus.r_changed), 256'(6'h04));
    chk("write_no_valid",  256'(bus.r_valid),   256'(0));
    cycle(0, 0, 0, 0, 0, 0);
    chk("idle_chg_clear",  256'(bus.r_changed), 256'(0));

    cycle(0, 1, 1, 5, 4'hF, 32'h12345678);
    cycle(0, 1, 0, 5, 4'h0, 32'h0);
    chk("b2b_valid", 256'(bus.r_valid),    256'(1));
    chk("b2b_data",  256'(bus.r_data_out), 256'(32'h12345678));

    cycle(0, 1, 0, 7, 4'h0, 32'h0);
    chk("oor_rd_valid", 256'(bus.r_valid),    256'(1));
    chk("oor_rd_err",   256'(bus.r_err),      256'(1));
    chk("oor_rd_data",  256'(bus.r_data_out), 256'(0));
    cycle(0, 1, 1, 6, 4'hF, 32'hFFFFFFFF);
    chk("oor_wr_err", 256'(bus.r_err),     256'(1));
    chk("oor_wr_chg", 256'(bus.r_changed), 256'(0));
    chk("oor_wr_mem", 256'(bus.r_mem),
        256'({32'h12345678, 32'h0, 32'h0, 32'h00AD00EF, 32'h0, 32'h0}));

    for (int i = 0; i < 6; i++) cycle(0, 1, 1, t_addr[i], t_be[i], t_data[i]);
    for (int i = 0; i < 8; i++) cycle(0, 1, 0, c_AW'(i), 4'h0, 32'h0);
    cycle(0, 1, 1, 1, 4'hF, 32'h0BADF00D);
    cycle(0, 1, 0, 1, 4'h0, 32'h0);
    chk("raw_data", 256'(bus.r_data_out), 256'(32'h0BADF00D));
    cycle(0, 1, 1, 4, 4'h6, 32'h55667788);
    cycle(0, 0, 0, 0, 0, 0);

    cycle(0, 1, 0, 2, 4'h0, 32'h0);
    cycle(1, 1, 0, 3, 4'h0, 32'h0);
    chk("rst_midread_valid", 256'(bus.r_valid), 256'(0));
    chk("rst_midread_mem",   256'(bus.r_mem),   256'(0));
    cycle(0, 0, 0, 0, 0, 0);

`ifdef IO_REGISTER_BANK_HW_SET_EN
    hw_we_nx = 6'b000010; hw_data_nx[1*c_DW +: c_DW] = 32'hA5A5A5A5;
    cycle(0, 1, 1, 1, 4'hF, 32'h00000001);
    chk("hw_sw_collide_reg1", 256'(bus.r_mem[1*c_DW +: c_DW]), 256'(32'h1));
    chk("hw_sw_collide_chg",  256'(bus.r_changed), 256'(6'h02));
    hw_we_nx = 6'b001000; hw_data_nx[3*c_DW +: c_DW] = 32'h5A5A5A5A;
    cycle(0, 1, 0, 3, 4'h0, 32'h0);
    chk("hw_read_old", 256'(bus.r_data_out), 256'(0));
    chk("hw_no_chg",   256'(bus.r_changed),  256'(0));
    cycle(0, 1, 0, 3, 4'h0, 32'h0);
    chk("hw_read_new", 256'(bus.r_data_out), 256'(32'h5A5A5A5A));
    hw_we_nx = 6'b111111; hw_data_nx = '1;
    cycle(1, 0, 0, 0, 0, 0);
    chk("hw_rst_override", 256'(bus.r_mem), 256'(0));
`endif

    cycle(0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
